div_stream_ctrl: RTL and testbench
==================================

Name: div_stream_ctrl

Overview:
Sequential issue/retire stage wrapped around the existing combinational `div` unit (ports `in1`, `in2`, `out`, `dbz`). It buffers incoming operand pairs in a small FIFO and presents the FIFO head to `div`. It registers the quotient and divide-by-zero flag into a result slot with a valid/ready handshake, and counts divide-by-zero events. This lets the rest of the datapath stream divisions at one per cycle with backpressure.

Parameters:
WIDTH, 8, operand/quotient width; must match the `div` instance width
DEPTH, 4, operand FIFO entries; power of two, >= 2
CNT_W, 8, width of the divide-by-zero event counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair offered
in_ready  out  1  FIFO can accept (not full)
in_dividend  in  WIDTH  unsigned dividend
in_divisor  in  WIDTH  unsigned divisor
div_in1  out  WIDTH  to `div.in1`: FIFO head dividend
div_in2  out  WIDTH  to `div.in2`: FIFO head divisor
div_out  in  WIDTH  from `div.out`
div_dbz  in  1  from `div.dbz`
res_valid  out  1  result slot holds a result
res_ready  in  1  consumer accepts result
res_quot  out  WIDTH  registered quotient
res_dbz  out  1  registered divide-by-zero flag
dbz_count  out  CNT_W  saturating count of retired dbz results

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high. Both are fixed.
- Reset values:
  - `in_ready` = 1 (FIFO empty).
  - `res_valid` = 0, `res_quot` = 0, `res_dbz` = 0, `dbz_count` = 0.
  - FIFO pointers and occupancy = 0.
  - `div_in1`/`div_in2` = 0 while the FIFO is empty.
- Push: on an edge with `in_valid && in_ready`, write the operands at the write pointer and advance it. The pointer wraps modulo DEPTH.
- `in_ready` = (occupancy != DEPTH). It depends only on registered occupancy; there is no same-cycle pass-through when full.
- Head: `div_in1`/`div_in2` are driven from the storage entry at the read pointer. They are held at 0 when empty, so `div` sees stable registered values.
- Retire condition:
  - `fire` = FIFO non-empty && (!res_valid || res_ready).
  - On `fire`: `res_quot` <= `div_out`, `res_dbz` <= `div_dbz`, `res_valid` <= 1, and pop the FIFO.
- When `div_dbz`=1, `res_quot` is forced to all-ones (`DBZ_QUOT`) regardless of `div_out`.
- When `res_valid && res_ready && !fire`, `res_valid` <= 0. The `res_quot`/`res_dbz` values are held.
- `dbz_count` increments on each `fire` with `div_dbz`=1 and saturates at 2^CNT_W-1.
- Latency: an operand accepted at edge N appears with `res_valid`=1 after edge N+1 (2 cycles from offer to result).
- Throughput: one result per cycle when `res_ready` is held high.
- Total capacity with `res_ready`=0 is DEPTH+1 (FIFO plus result slot).
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - When full with `fire`, the push is still refused that cycle, because `in_ready` was 0.
  - When empty, a push is not popped in the same cycle; there is no bypass.
- Ordering: results retire strictly in acceptance order.
- Reset mid-operation: all queued operands and any pending result are discarded. `dbz_count` is cleared. Outputs match the reset values on the next cycle.

Decomposition:
- Shared package `div_pkg`:
  - `DIV_WIDTH_DEF` = 8.
  - Function/constant `DBZ_QUOT` = all-ones of WIDTH.
  - Typedef `div_op_t` {dividend, divisor}.
- Sub-module `div_op_fifo`: synchronous FIFO of `div_op_t` with full/empty/occupancy outputs and wrap-around pointers.
- `div_stream_ctrl` instantiates `div_op_fifo` and owns the result slot and counter. The `div` unit is instantiated beside it by the parent and connected through the `div_*` ports.
- The bench instantiates `div_stream_ctrl` together with a real `div` instance.

Test Plan:
- Single op: push 100/7 with `res_ready`=1 → `res_valid` 2 cycles after acceptance with `res_quot`=14, `res_dbz`=0; `dbz_count`=0.
- Divide-by-zero: push 255/0 → `res_quot`=0xFF, `res_dbz`=1, `dbz_count`=1. Then push 0/0 → `dbz_count`=2.
- Backpressure: hold `res_ready`=0 and offer 7 ops (10/1..70/1) → exactly 5 accepted, and `in_ready`=0 from the cycle after the 5th acceptance. Release `res_ready` → quotients 10,20,30,40,50 in order, then `in_ready` returns to 1.
- Streaming sweep: all 65536 (i,j) pairs back-to-back with `res_ready`=1 → one result per cycle after the 2-cycle fill. Each result equals i/j for j!=0, or 0xFF with `dbz`=1 for j=0. Final `dbz_count`=255 (saturated; 256 events).
- Random `res_ready` (50%) over 1000 random ops → the in-order scoreboard matches and no result is lost or duplicated.
- Reset mid-stream: with 3 ops queued and `res_valid`=1, assert `rst` for one cycle → the next cycle has `res_valid`=0, `in_ready`=1, `dbz_count`=0, and no stale result emerges afterwards.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue/retire stage.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 8;

  // Quotient reported for a divide-by-zero at the default width.
  localparam logic [DIV_WIDTH_DEF-1:0] DBZ_QUOT = '1;

  typedef struct packed {
    logic [DIV_WIDTH_DEF-1:0] dividend;
    logic [DIV_WIDTH_DEF-1:0] divisor;
  } div_op_t;

endpackage

// File: rtl/div.sv
// Combinational unsigned divider; dbz flags a zero divisor and the quotient is 0 then.
module div #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             dbz
);

  assign dbz = (in2 == '0);
  assign out = dbz ? '0 : (in1 / in2);

endmodule

// File: rtl/div_op_fifo.sv
// Synchronous operand FIFO with wrap-around pointers and an occupancy count.
module div_op_fifo
  import div_pkg::*;
#(
  parameter type op_t  = div_op_t,
  parameter int  DEPTH = 4,
  parameter int  AW    = $clog2(DEPTH),
  parameter int  CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  op_t           wdata,
  input  logic          pop,
  output op_t           rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] occupancy
);

  op_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Requests are qualified here so a stray push/pop can never corrupt pointers.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full  = (occupancy == CW'(DEPTH));
  assign empty = (occupancy == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/div_stream_ctrl.sv
// Issue/retire stage around an external combinational divider: operand FIFO in,
// registered result slot out, plus a saturating divide-by-zero counter.
module div_stream_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic [WIDTH-1:0] div_in1,
  output logic [WIDTH-1:0] div_in2,
  input  logic [WIDTH-1:0] div_out,
  input  logic             div_dbz,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_quot,
  output logic             res_dbz,
  output logic [CNT_W-1:0] dbz_count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and ready depends only on registered state.

  typedef struct packed {
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
  } op_t;

  localparam int                OCC_W      = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0]  DBZ_QUOT_W = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  op_t              push_op;
  op_t              head_op;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OCC_W-1:0] occupancy;
  logic             push;
  logic             fire;

  assign push_op  = '{dividend: in_dividend, divisor: in_divisor};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  // Retire whenever there is a head operand and the slot is free or being drained.
  assign fire = (occupancy != '0) && (!res_valid || res_ready);

  div_op_fifo #(
    .op_t  (op_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wdata     (push_op),
    .pop       (fire),
    .rdata     (head_op),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  // The divider sees zeros rather than stale storage while nothing is queued.
  assign div_in1 = fifo_empty ? '0 : head_op.dividend;
  assign div_in2 = fifo_empty ? '0 : head_op.divisor;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_quot  <= '0;
      res_dbz   <= 1'b0;
      dbz_count <= '0;
    end else if (fire) begin
      res_valid <= 1'b1;
      res_quot  <= div_dbz ? DBZ_QUOT_W : div_out;
      res_dbz   <= div_dbz;
      if (div_dbz && (dbz_count != CNT_MAX)) begin
        dbz_count <= dbz_count + CNT_W'(1);
      end
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_stream_ctrl.sv
// Directed bench for div_stream_ctrl paired with a real div instance.
module tb_div_stream_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic [WIDTH-1:0] div_in1;
  logic [WIDTH-1:0] div_in2;
  logic [WIDTH-1:0] div_out;
  logic             div_dbz;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_quot;
  logic             res_dbz;
  logic [CNT_W-1:0] dbz_count;

  int tests  = 0;
  int failed = 0;

  // Scoreboard entries are {dbz, quotient}.
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] exp_e;

  int acc;
  int sent;
  int received;
  int cycles;
  int a;
  int b;
  int ei;
  int ej;
  bit just_acc;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  div #(.WIDTH(WIDTH)) u_div (
    .in1 (div_in1),
    .in2 (div_in2),
    .out (div_out),
    .dbz (div_dbz)
  );

  div_stream_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .div_in1     (div_in1),
    .div_in2     (div_in2),
    .div_out     (div_out),
    .div_dbz     (div_dbz),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_quot    (res_quot),
    .res_dbz     (res_dbz),
    .dbz_count   (dbz_count)
  );

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic offer(input int dd, input int dv);
    in_valid    = 1'b1;
    in_dividend = WIDTH'(dd);
    in_divisor  = WIDTH'(dv);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model(input int x, input int y);
    if (y == 0) return {1'b1, {WIDTH{1'b1}}};
    return {1'b0, WIDTH'(x / y)};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    res_ready   = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_quot", res_quot, 0);
    check("rst_res_dbz", res_dbz, 0);
    check("rst_dbz_count", dbz_count, 0);
    check("rst_div_in1", div_in1, 0);
    check("rst_div_in2", div_in2, 0);

    // Single op 100/7
    offer(100, 7);
    step();
    in_valid = 1'b0;
    check("single_head_in1", div_in1, 100);
    check("single_head_in2", div_in2, 7);
    check("single_not_yet", res_valid, 0);
    step();
    check("single_valid", res_valid, 1);
    check("single_quot", res_quot, 14);
    check("single_dbz", res_dbz, 0);
    check("single_count", dbz_count, 0);
    step();
    check("single_drained", res_valid, 0);

    // Divide-by-zero 255/0 then 0/0
    offer(255, 0);
    step();
    in_valid = 1'b0;
    step();
    check("dbz1_quot", res_quot, 8'hFF);
    check("dbz1_flag", res_dbz, 1);
    check("dbz1_count", dbz_count, 1);
    offer(0, 0);
    step();
    in_valid = 1'b0;
    step();
    check("dbz2_quot", res_quot, 8'hFF);
    check("dbz2_count", dbz_count, 2);
    step();

    // Backpressure: 7 offers with res_ready low, DEPTH+1 fit
    res_ready = 1'b0;
    acc = 0;
    for (int k = 1; k <= 7; k++) begin
      offer(10 * k, 1);
      just_acc = in_ready;
      if (just_acc) acc++;
      step();
      if (just_acc && acc == 5) check("bp_full_after_5th", in_ready, 0);
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 5);
    check("bp_slot_valid", res_valid, 1);
    check("bp_quot_0", res_quot, 10);
    res_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      step();
      check("bp_order_valid", res_valid, 1);
      check("bp_order_quot", res_quot, 10 * k);
    end
    check("bp_ready_back", in_ready, 1);
    step();
    check("bp_drained", res_valid, 0);

    // Streaming sweep over all operand pairs
    do_reset();
    check("sweep_count_start", dbz_count, 0);
    res_ready = 1'b1;
    for (int n = 0; n < 65536 + 1; n++) begin
      if (n < 65536) begin
        ei = n / 256;
        ej = n % 256;
        offer(ei, ej);
        if (in_ready) exp_q.push_back(model(ei, ej));
        else check("sweep_in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (n >= 1) begin
        check("sweep_valid", res_valid, 1);
        if (exp_q.size() == 0) begin
          check("sweep_queue_empty", 0, 1);
        end else begin
          exp_e = exp_q.pop_front();
          check("sweep_result", {res_dbz, res_quot}, exp_e);
        end
      end
    end
    check("sweep_dbz_sat", dbz_count, 255);
    check("sweep_leftover", exp_q.size(), 0);
    step();
    check("sweep_drained", res_valid, 0);

    // Random res_ready over 1000 random ops
    do_reset();
    exp_q.delete();
    sent = 0;
    received = 0;
    cycles = 0;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    while (received < 1000 && cycles < 20000) begin
      res_ready = 1'($urandom_range(0, 1));
      if (sent < 1000) offer(a, b);
      else in_valid = 1'b0;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_spurious", 0, 1);
        end else begin
          exp_e = exp_q.pop_front();
          check("rand_result", {res_dbz, res_quot}, exp_e);
        end
        received++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b));
        sent++;
        a = $urandom_range(0, 255);
        b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      end
      step();
      cycles++;
    end
    in_valid = 1'b0;
    check("rand_received", received, 1000);
    check("rand_leftover", exp_q.size(), 0);

    // Reset mid-stream with 3 queued ops and a pending result
    do_reset();
    res_ready = 1'b0;
    offer(5, 0);
    step();
    offer(6, 1);
    step();
    offer(7, 1);
    step();
    offer(8, 1);
    step();
    in_valid = 1'b0;
    check("mid_slot_valid", res_valid, 1);
    check("mid_slot_dbz", res_dbz, 1);
    check("mid_count", dbz_count, 1);
    check("mid_head_in1", div_in1, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_count", dbz_count, 0);
    check("mid_rst_quot", res_quot, 0);
    check("mid_rst_in1", div_in1, 0);
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("mid_no_stale", res_valid, 0);
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
